// File: rtl/usb_pkg.sv
// Shared constants and state encoding for the USB transmit-path scheduler.
package usb_pkg;

  localparam int USB_MAX_BYTES = 64;
  localparam int USB_SIZE_W    = 9;
  localparam int USB_BUF_W     = 512;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    GAP
  } tx_sched_state_t;

endpackage

// File: rtl/usb_rr_picker.sv
// Combinational round-robin picker: first set request after the last winner.
module usb_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_last,
  output logic [IW-1:0]      o_idx,
  output logic               o_found
);

  logic [IW-1:0] w_cand;

  always_comb begin
    // NOTE: every signal written here is defaulted first, so no path can infer a latch.
    o_found = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    // Offsets 1..NUM_REQ visit every requester once, ending on the last winner itself.
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IW'((int'(i_last) + k) % NUM_REQ);
      if (!o_found && i_req[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/usb_tx_scheduler.sv
// Round-robin owner of the single USB transmit path: grant, start, wait for
// done or timeout, then hold an inter-packet gap before the next grant.
module usb_tx_scheduler
  import usb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int MAX_BYTES      = USB_MAX_BYTES,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 4
) (
  input  logic                                HPS_USB_CLKOUT,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  reqValid,
  input  logic [NUM_REQ-1:0][USB_BUF_W-1:0]   reqData,
  input  logic [NUM_REQ-1:0][USB_SIZE_W-1:0]  reqSize,
  output logic [NUM_REQ-1:0]                  reqAck,
  output logic [NUM_REQ-1:0]                  reqDone,
  output logic [NUM_REQ-1:0]                  reqError,
  input  logic                                rxBusy,
  input  logic                                txDone,
  output logic [USB_BUF_W-1:0]                txBuffer,
  output logic [USB_SIZE_W-1:0]               txSize,
  output logic                                startTransmit,
  output logic                                busy,
  output logic [$clog2(NUM_REQ)-1:0]          grantIdx
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  tx_sched_state_t r_state, w_state_nxt;
  logic [IW-1:0]   r_last_grant;
  logic [TW-1:0]   r_tcnt, w_tcnt_nxt;
  logic [GW-1:0]   r_gcnt, w_gcnt_nxt;

  logic [IW-1:0]         w_win;
  logic                  w_found;
  logic [USB_SIZE_W-1:0] w_win_size;
  logic                  w_size_ok;
  logic [NUM_REQ-1:0]    w_win_1h, w_grant_1h;
  logic [NUM_REQ-1:0]    w_ack_nxt, w_done_nxt, w_err_nxt;
  logic                  w_start_nxt, w_take, w_load;

  usb_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .i_req   (reqValid),
    .i_last  (r_last_grant),
    .o_idx   (w_win),
    .o_found (w_found)
  );

  assign w_win_size = reqSize[w_win];
  assign w_size_ok  = (w_win_size != '0) && (w_win_size <= USB_SIZE_W'(MAX_BYTES));
  assign w_win_1h   = NUM_REQ'(1) << w_win;
  assign w_grant_1h = NUM_REQ'(1) << grantIdx;

  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    w_gcnt_nxt  = r_gcnt;
    w_ack_nxt   = '0;
    w_done_nxt  = '0;
    w_err_nxt   = '0;
    w_start_nxt = 1'b0;
    w_take      = 1'b0;
    w_load      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!rxBusy && w_found) begin
          w_ack_nxt = w_win_1h;
          w_take    = 1'b1;
          if (w_size_ok) begin
            w_load      = 1'b1;
            w_state_nxt = START;
          end else begin
            w_err_nxt = w_win_1h;
          end
        end
      end
      START: begin
        w_start_nxt = 1'b1;
        w_tcnt_nxt  = '0;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        // A done arriving on the timeout cycle still counts as a success.
        if (txDone) begin
          w_done_nxt  = w_grant_1h;
          w_gcnt_nxt  = '0;
          w_state_nxt = GAP;
        end else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          w_err_nxt   = w_grant_1h;
          w_gcnt_nxt  = '0;
          w_state_nxt = GAP;
        end else begin
          w_tcnt_nxt = r_tcnt + TW'(1);
        end
      end
      GAP: begin
        if (r_gcnt == GW'(GAP_CYCLES - 1)) begin
          w_state_nxt = IDLE;
        end else begin
          w_gcnt_nxt = r_gcnt + GW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge HPS_USB_CLKOUT or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_last_grant  <= IW'(NUM_REQ - 1);
      r_tcnt        <= '0;
      r_gcnt        <= '0;
      reqAck        <= '0;
      reqDone       <= '0;
      reqError      <= '0;
      startTransmit <= 1'b0;
      busy          <= 1'b0;
      txBuffer      <= '0;
      txSize        <= '0;
      grantIdx      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_tcnt        <= w_tcnt_nxt;
      r_gcnt        <= w_gcnt_nxt;
      reqAck        <= w_ack_nxt;
      reqDone       <= w_done_nxt;
      reqError      <= w_err_nxt;
      startTransmit <= w_start_nxt;
      busy          <= (w_state_nxt != IDLE);
      if (w_take) begin
        r_last_grant <= w_win;
      end
      if (w_load) begin
        txBuffer <= reqData[w_win];
        txSize   <= w_win_size;
        grantIdx <= w_win;
      end
    end
  end

endmodule

// File: doc/usb_tx_scheduler.md
# usb_tx_scheduler

Round-robin scheduler that shares the USB transceiver's single transmit path between `NUM_REQ` requesters. It captures the winning requester's packet buffer and byte count, issues a one-cycle transmit start to the transceiver, and waits for completion or timeout. It then enforces an inter-packet gap before the next grant. It sits between the host-side packet sources and `USBTransceiver`, in the `HPS_USB_CLKOUT` domain.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `MAX_BYTES`, 64: largest legal packet; equals the 512-bit buffer width / 8.
- `TIMEOUT_CYCLES`, 4096: cycles allowed in WAIT before the transfer is aborted.
- `GAP_CYCLES`, 4: idle cycles after each transfer (≥1).

Ports:
- `HPS_USB_CLKOUT`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `reqValid`  in  NUM_REQ: requester i has a packet pending; held until `reqAck[i]`.
- `reqData`  in  NUM_REQ×512: packet bytes, byte k at bits [8k+7:8k].
- `reqSize`  in  NUM_REQ×9: byte count.
- `reqAck`  out  NUM_REQ: one-cycle pulse; request consumed, requester may change inputs.
- `reqDone`  out  NUM_REQ: one-cycle pulse; packet transmitted.
- `reqError`  out  NUM_REQ: one-cycle pulse; size illegal or timeout.
- `rxBusy`  in  1: transceiver is receiving; no new start issued while high.
- `txDone`  in  1: one-cycle pulse from the transmit path when the packet ends (STP issued).
- `txBuffer`  out  512: registered copy of the granted `reqData`, drives `dataBufferIn`.
- `txSize`  out  9: registered granted size, drives `dataSizeIn`.
- `startTransmit`  out  1: one-cycle start pulse to the transceiver.
- `busy`  out  1: high in every state except IDLE.
- `grantIdx`  out  $clog2(NUM_REQ): index of the current or last grant.

## Operation
- States: IDLE, START, WAIT, GAP.
- **IDLE:** if `rxBusy`=0 and any `reqValid`, pick the winner w by round-robin. The search starts at `lastGrant+1` mod NUM_REQ and takes the first set bit.
  - Legal size (1..MAX_BYTES): register `txBuffer`/`txSize`/`grantIdx`=w, set `lastGrant`=w, pulse `reqAck[w]`, go to START.
  - Illegal size (0 or >MAX_BYTES): pulse `reqAck[w]` and `reqError[w]` together, set `lastGrant`=w, stay in IDLE. No start is issued.
- **START:** `startTransmit`=1 for exactly one cycle. Clear the timeout counter. Go to WAIT.
- **WAIT:** count cycles.
  - `txDone` → pulse `reqDone[grantIdx]`, go to GAP.
  - Counter reaches TIMEOUT_CYCLES−1 without `txDone` → pulse `reqError[grantIdx]`, go to GAP.
  - `txDone` and timeout in the same cycle → done wins; no error.
- **GAP:** count GAP_CYCLES cycles, then go to IDLE.
- `txDone` outside WAIT is ignored.
- `rxBusy` is checked only in IDLE. Once START is entered, the transfer proceeds regardless of `rxBusy`.
- `reqValid` dropped before its ack is not an error; the requester simply loses the round.
- `txBuffer`/`txSize` hold their values from grant until the next legal grant.
- Reset (asynchronous, any state, including mid-WAIT):
  - State → IDLE, `lastGrant` → NUM_REQ−1 (requester 0 has first priority).
  - Counters, `txBuffer`, `txSize`, `grantIdx` → 0.
  - `startTransmit`, `reqAck`, `reqDone`, `reqError`, `busy` → 0.
  - An in-flight packet receives no done or error pulse.

## Timing
- All outputs are registered.
- Request present in IDLE at edge n → `reqAck` and START visible after edge n; `startTransmit` high during cycle n+1 → n+2 (one cycle).
- Grant-to-start latency is 1 cycle; the minimum request-to-start latency is 2 edges.
- `txDone` at edge m → `reqDone` high in cycle m..m+1, then GAP for GAP_CYCLES.
- The earliest next grant is at edge m+GAP_CYCLES+1.
- Timeout fires at the TIMEOUT_CYCLES-th WAIT cycle.
- The counter is $clog2(TIMEOUT_CYCLES+1) bits wide; it never wraps.
- Back-to-back illegal requests are rejected at one per cycle.

## Structure
- Package `usb_pkg`:
  - `USB_MAX_BYTES`=64, `USB_SIZE_W`=9, `USB_BUF_W`=512.
  - `tx_sched_state_t` enum {IDLE, START, WAIT, GAP}.
- Sub-module `usb_rr_picker`: combinational round-robin (req vector, last index → winner index, found flag).
- Requester buses are packed arrays indexed by requester.

## Test plan
- Single request: req0, size 3, `txDone` 5 cycles after start → `reqAck[0]` 1 cycle, 1 `startTransmit` pulse, `txSize`=3, `reqDone[0]` 1 cycle, `busy` low after 4 gap cycles.
- Fairness: all 4 `reqValid` held continuously, each `txDone` immediate → grant order 0,1,2,3,0 with exactly one start per grant.
- Illegal sizes: req2 size 0, then size 65 → `reqAck[2]` and `reqError[2]` together each time, no `startTransmit`, state remains IDLE.
- Timeout: req1 granted, `txDone` never asserted → `reqError[1]` at WAIT cycle 4096, next grant after 4 gap cycles. Repeat with `txDone` on the timeout cycle → `reqDone[1]` only.
- Receive hold-off: `rxBusy`=1 with req3 pending → no ack for 20 cycles; `rxBusy` drops → ack on the next edge.
- Reset during WAIT → all outputs 0 in the same cycle, no done/error pulse; first grant after release goes to req0 when all requesters are pending.
